// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Next-PC predictor for the IF stage of the 5-stage core. A direct-mapped
// branch target buffer (BTB) supplies the taken target, and a table of 2-bit
// saturating counters (PHT) supplies the direction. Lookup is purely
// combinational on if_pc; training arrives from EX when a control-flow
// instruction resolves and takes effect on the rising clock edge.
//
// Build option:
//   BP_GSHARE_EN defined   : PHT indexed by idx(pc) XOR global history, and
//                            the global history register shifts on each update.
//   BP_GSHARE_EN undefined : bimodal predictor, PHT indexed by idx(pc), the
//                            history register stays at zero, upd_ghr ignored.
//
// Parameters:
//   XLEN      - address width
//   ENTRIES   - BTB / PHT depth (power of two, >= 4)
//   GHR_WIDTH - global history length (<= log2(ENTRIES))
//
// Ports:
//   clk          in   clock, all state updates on rising edge
//   reset        in   synchronous active-high reset
//   if_pc        in   PC being fetched
//   pred_taken   out  predicted taken
//   pred_next_pc out  predicted next fetch PC
//   pred_ghr     out  history used for this prediction
//   upd_valid    in   a branch/jump resolved this cycle
//   upd_pc       in   PC of the resolved instruction
//   upd_taken    in   actual direction
//   upd_target   in   actual taken target
//   upd_ghr      in   pred_ghr captured when the instruction was fetched
// -----------------------------------------------------------------------------
module branch_predictor #(
  parameter int XLEN      = 32,
  parameter int ENTRIES   = 32,
  parameter int GHR_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [XLEN-1:0]      if_pc,
  output logic                 pred_taken,
  output logic [XLEN-1:0]      pred_next_pc,
  output logic [GHR_WIDTH-1:0] pred_ghr,
  input  logic                 upd_valid,
  input  logic [XLEN-1:0]      upd_pc,
  input  logic                 upd_taken,
  input  logic [XLEN-1:0]      upd_target,
  input  logic [GHR_WIDTH-1:0] upd_ghr
);

  localparam int IW = $clog2(ENTRIES);
  localparam int TW = XLEN - IW - 2;

  // Counter value loaded on reset: weakly not-taken.
  localparam logic [1:0] PHT_RESET = 2'b01;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                 valid_q  [ENTRIES];
  logic [TW-1:0]        tag_q    [ENTRIES];
  logic [XLEN-1:0]      target_q [ENTRIES];
  logic [1:0]           pht_q    [ENTRIES];
  logic [GHR_WIDTH-1:0] ghr_q;

  // Next-state values for the single PHT entry and the history register
  // touched by an update.
  logic [1:0]           pht_d;
  logic [GHR_WIDTH-1:0] ghr_d;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  // Zero-extend a history value to the table index width.
  function automatic logic [IW-1:0] ghr_ext(input logic [GHR_WIDTH-1:0] h);
    logic [IW-1:0] r;
    r = '0;
    r[GHR_WIDTH-1:0] = h;
    return r;
  endfunction

  // Saturating 2-bit counter step.
  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
    logic [1:0] r;
    r = c;
    if (up) begin
      if (c != 2'b11) r = c + 2'd1;
    end else begin
      if (c != 2'b00) r = c - 2'd1;
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Lookup path (combinational on if_pc)
  // ---------------------------------------------------------------------------
  logic [IW-1:0] lk_idx;
  logic [TW-1:0] lk_tag;
  logic [IW-1:0] lk_pidx;
  logic          lk_hit;

  assign lk_idx = if_pc[IW+1:2];
  assign lk_tag = if_pc[XLEN-1:IW+2];

`ifdef BP_GSHARE_EN
  assign lk_pidx = lk_idx ^ ghr_ext(ghr_q);
`else
  assign lk_pidx = lk_idx;
`endif

  assign lk_hit       = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken   = lk_hit && pht_q[lk_pidx][1];
  // Sequential fetch wraps modulo 2^XLEN by plain truncation of the add.
  assign pred_next_pc = pred_taken ? target_q[lk_idx] : (if_pc + XLEN'(4));
  assign pred_ghr     = ghr_q;

  // ---------------------------------------------------------------------------
  // Update path
  // ---------------------------------------------------------------------------
  logic [IW-1:0] up_idx;
  logic [TW-1:0] up_tag;
  logic [IW-1:0] up_pidx;

  assign up_idx = upd_pc[IW+1:2];
  assign up_tag = upd_pc[XLEN-1:IW+2];

`ifdef BP_GSHARE_EN
  // upd_ghr is the history the prediction actually used, so training lands on
  // the same PHT entry the lookup consulted even if GHR has moved since.
  assign up_pidx = up_idx ^ ghr_ext(upd_ghr);
`else
  assign up_pidx = up_idx;
`endif

  // Shift through a one-bit-wider vector so GHR_WIDTH == 1 needs no special case.
  logic [GHR_WIDTH:0] ghr_shift;
  assign ghr_shift = {ghr_q, upd_taken};

  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    pht_d = pht_q[up_pidx];
    ghr_d = ghr_q;
    pht_d = sat_step(pht_q[up_pidx], upd_taken);
`ifdef BP_GSHARE_EN
    ghr_d = ghr_shift[GHR_WIDTH-1:0];
`else
    ghr_d = '0;
`endif
  end

  // Control state: BTB valid bits, PHT counters and history. Reset wins over
  // any update presented on the same edge.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        pht_q[i]   <= PHT_RESET;
      end
      ghr_q <= '0;
    end else if (upd_valid) begin
      pht_q[up_pidx] <= pht_d;
      ghr_q          <= ghr_d;
      if (upd_taken) valid_q[up_idx] <= 1'b1;
    end
  end

  // BTB payload. A taken update overwrites whatever alias occupied the slot;
  // a not-taken update never touches the BTB.
  always_ff @(posedge clk) begin
    // NOTE: tag and target arrays are deliberately not reset; the valid bit
    // gates their use, which keeps these as plain RAM without a reset sweep.
    if (!reset && upd_valid && upd_taken) begin
      tag_q[up_idx]    <= up_tag;
      target_q[up_idx] <= upd_target;
    end
  end

  // PC bits [1:0] never participate in indexing or tagging.
`ifdef BP_GSHARE_EN
  logic unused_bits;
  assign unused_bits = ^{if_pc[1:0], upd_pc[1:0]};
`else
  logic unused_bits;
  assign unused_bits = ^{if_pc[1:0], upd_pc[1:0], upd_ghr};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
//
// Directed self-checking bench for branch_predictor with XLEN=32, ENTRIES=32,
// GHR_WIDTH=5 (idx = pc[6:2], tag = pc[31:7]). Expected values are hand
// computed; the gshare-specific sequence is selected by BP_GSHARE_EN so the
// same bench serves both builds.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

  localparam int XLEN      = 32;
  localparam int ENTRIES   = 32;
  localparam int GHR_WIDTH = 5;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [XLEN-1:0]      if_pc;
  logic                 pred_taken;
  logic [XLEN-1:0]      pred_next_pc;
  logic [GHR_WIDTH-1:0] pred_ghr;
  logic                 upd_valid;
  logic [XLEN-1:0]      upd_pc;
  logic                 upd_taken;
  logic [XLEN-1:0]      upd_target;
  logic [GHR_WIDTH-1:0] upd_ghr;

  int checks = 0;
  int errors = 0;

  branch_predictor #(
    .XLEN      (XLEN),
    .ENTRIES   (ENTRIES),
    .GHR_WIDTH (GHR_WIDTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .if_pc        (if_pc),
    .pred_taken   (pred_taken),
    .pred_next_pc (pred_next_pc),
    .pred_ghr     (pred_ghr),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .upd_taken    (upd_taken),
    .upd_target   (upd_target),
    .upd_ghr      (upd_ghr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply a fetch PC and compare all three prediction outputs.
  task automatic look(input string name, input logic [31:0] pc, input logic exp_t,
                      input logic [31:0] exp_npc, input logic [4:0] exp_g);
    if_pc = pc;
    #1;
    check({name, ".taken"}, 32'(pred_taken), 32'(exp_t));
    check({name, ".npc"},   pred_next_pc,    exp_npc);
    check({name, ".ghr"},   32'(pred_ghr),   32'(exp_g));
  endtask

  // Present one resolved branch for exactly one rising edge.
  task automatic upd(input logic [31:0] pc, input logic taken,
                     input logic [31:0] target, input logic [4:0] g);
    upd_pc     = pc;
    upd_taken  = taken;
    upd_target = target;
    upd_ghr    = g;
    upd_valid  = 1'b1;
    tick();
    upd_valid  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    if_pc      = '0;
    upd_valid  = 1'b0;
    upd_pc     = '0;
    upd_taken  = 1'b0;
    upd_target = '0;
    upd_ghr    = '0;

    // Outputs while reset is held, from the cycle after the first reset edge.
    tick();
    tick();
    look("rst_hold", 32'h100, 1'b0, 32'h104, 5'd0);
    reset = 1'b0;
    tick();

`ifndef BP_GSHARE_EN
    // Same-cycle lookup sees pre-update state; next cycle sees the new entry.
    if_pc      = 32'h40;
    upd_pc     = 32'h40;
    upd_taken  = 1'b1;
    upd_target = 32'h80;
    upd_ghr    = '0;
    upd_valid  = 1'b1;
    #1;
    check("simul.npc",   pred_next_pc,    32'h44);
    check("simul.taken", 32'(pred_taken), 32'd0);
    tick();
    upd_valid = 1'b0;
    look("learn", 32'h40, 1'b1, 32'h80, 5'd0);           // counter 10

    // Saturation on PHT[16].
    upd(32'h40, 1'b1, 32'h80, 5'd0);
    upd(32'h40, 1'b1, 32'h80, 5'd0);
    upd(32'h40, 1'b1, 32'h80, 5'd0);                     // 11
    look("sat_hi", 32'h40, 1'b1, 32'h80, 5'd0);
    upd(32'h40, 1'b0, 32'h0, 5'd0);                      // 10
    look("nt1", 32'h40, 1'b1, 32'h80, 5'd0);
    upd(32'h40, 1'b0, 32'h0, 5'd0);                      // 01
    look("nt2", 32'h40, 1'b0, 32'h44, 5'd0);
    upd(32'h40, 1'b0, 32'h0, 5'd0);                      // 00
    look("nt3", 32'h40, 1'b0, 32'h44, 5'd0);
    upd(32'h40, 1'b0, 32'h0, 5'd0);                      // stays 00
    upd(32'h40, 1'b1, 32'h80, 5'd0);                     // 01, not 10
    look("sat_lo", 32'h40, 1'b0, 32'h44, 5'd0);

    // Tag alias at idx 16: 0x40 (tag 0) vs 0xC0 (tag 1).
    do_reset();
    upd(32'h40, 1'b1, 32'h80, 5'd0);                     // PHT16=10
    look("alias_own",  32'h40, 1'b1, 32'h80, 5'd0);
    look("alias_miss", 32'hC0, 1'b0, 32'hC4, 5'd0);
    upd(32'hC0, 1'b1, 32'h200, 5'd0);                    // evicts 0x40, PHT16=11
    look("alias_new",  32'hC0, 1'b1, 32'h200, 5'd0);
    look("evicted",    32'h40, 1'b0, 32'h44, 5'd0);

    // Not-taken update leaves the BTB alone (PHT16 11->10, still taken).
    upd(32'hC0, 1'b0, 32'h12345678, 5'd0);
    look("nt_keep_btb", 32'hC0, 1'b1, 32'h200, 5'd0);

    // upd_valid low: nothing changes even with a not-taken update on the bus.
    upd_pc    = 32'hC0;
    upd_taken = 1'b0;
    tick();
    tick();
    tick();
    look("no_valid", 32'hC0, 1'b1, 32'h200, 5'd0);

    // Reset in the middle of the run wipes the learned entry.
    do_reset();
    look("mid_reset", 32'hC0, 1'b0, 32'hC4, 5'd0);

    // PC wrap on the sequential path, then a taken entry at idx 31.
    look("wrap_miss", 32'hFFFF_FFFC, 1'b0, 32'h0, 5'd0);
    upd(32'hFFFF_FFFC, 1'b1, 32'h10, 5'd0);
    look("wrap_hit",  32'hFFFF_FFFC, 1'b1, 32'h10, 5'd0);
    look("idx31_alias", 32'h7C, 1'b0, 32'h80, 5'd0);

    // Reset dominates a simultaneous update.
    reset = 1'b1;
    upd(32'h40, 1'b1, 32'h80, 5'd0);
    reset = 1'b0;
    look("rst_dominates", 32'h40, 1'b0, 32'h44, 5'd0);
`else
    // Two taken updates with upd_ghr=0 drive PHT[16] to 11; GHR = 00011.
    upd(32'h40, 1'b1, 32'h80, 5'd0);
    upd(32'h40, 1'b1, 32'h80, 5'd0);
    // Lookup now indexes PHT[16^3=19], still 01.
    look("gs_idx19", 32'h40, 1'b0, 32'h44, 5'b00011);

    // Training uses upd_ghr, not the live GHR: train PHT[16^1=17].
    do_reset();
    upd(32'h40, 1'b1, 32'h80, 5'd1);                     // PHT17=10, GHR=00001
    look("gs_idx17", 32'h40, 1'b1, 32'h80, 5'b00001);
    // Same PC at a different history misses the trained counter.
    upd(32'h100, 1'b0, 32'h0, 5'd0);                     // GHR=00010
    look("gs_idx18", 32'h40, 1'b0, 32'h44, 5'b00010);

    // Taken, not-taken, not-taken from reset -> GHR = 00100.
    do_reset();
    upd(32'h48, 1'b1, 32'h90, 5'd0);
    upd(32'h48, 1'b0, 32'h0, 5'd1);
    upd(32'h48, 1'b0, 32'h0, 5'd2);
    look("gs_hist", 32'h100, 1'b0, 32'h104, 5'b00100);

    // upd_valid low leaves history untouched.
    upd_taken = 1'b1;
    tick();
    tick();
    look("gs_no_valid", 32'h100, 1'b0, 32'h104, 5'b00100);

    // Mid-run reset clears history and BTB.
    upd(32'h40, 1'b1, 32'h80, 5'd0);
    do_reset();
    look("gs_mid_reset", 32'h40, 1'b0, 32'h44, 5'd0);
    look("gs_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0, 5'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised next-PC predictor for the 5-stage pipelined core, replacing the fixed `current_pc + 4` next-PC path in IF. It combines a direct-mapped branch target buffer (BTB) with a table of 2-bit saturating counters (PHT) indexed gshare-style by PC XOR global history. Prediction is combinational on the IF PC. Training happens from the EX stage when a control-flow instruction resolves.

## Interface
- `XLEN`, 32: address/data width.
- `ENTRIES`, 32: BTB and PHT depth; power of two, ≥ 4.
- `GHR_WIDTH`, 5: global history length; must be ≤ log2(`ENTRIES`).

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `if_pc`  in  XLEN  PC of the instruction being fetched.
- `pred_taken`  out  1  predicted taken.
- `pred_next_pc`  out  XLEN  predicted next fetch PC.
- `pred_ghr`  out  GHR_WIDTH  history used for this prediction; carried down the pipe by the core.
- `upd_valid`  in  1  a branch/jump resolved in EX this cycle.
- `upd_pc`  in  XLEN  PC of the resolved instruction.
- `upd_taken`  in  1  actual direction.
- `upd_target`  in  XLEN  actual taken target.
- `upd_ghr`  in  GHR_WIDTH  `pred_ghr` value captured when this instruction was fetched.

## Operation
- Index bits: IW = log2(ENTRIES). idx(pc) = pc[IW+1:2]; tag(pc) = pc[XLEN-1:IW+2]. pc[1:0] is ignored.
- State:
  - BTB: valid[ENTRIES], tag[ENTRIES], target[ENTRIES].
  - PHT: 2-bit counter[ENTRIES].
  - GHR: GHR_WIDTH bits.
- PHT index: pidx(pc, h) = idx(pc) XOR zero-extend(h) to IW bits.
- Lookup, purely combinational:
  - hit = valid[idx(if_pc)] && tag[idx(if_pc)] == tag(if_pc).
  - pred_taken = hit && PHT[pidx(if_pc, GHR)][1].
  - pred_next_pc = pred_taken ? target[idx(if_pc)] : if_pc + 4. Arithmetic is modulo 2^XLEN, so PC wraps.
  - pred_ghr = GHR.
- Update, on rising edge with upd_valid=1:
  - PHT[pidx(upd_pc, upd_ghr)]: upd_taken increments, saturating at 3; otherwise decrements, saturating at 0.
  - If upd_taken: BTB[idx(upd_pc)] ← {valid=1, tag(upd_pc), upd_target}, overwriting any alias.
  - A not-taken update leaves the BTB untouched.
  - GHR ← {GHR[GHR_WIDTH-2:0], upd_taken}. History is non-speculative and updated at resolution only.
- upd_valid=0: no state change.
- Reset, dominates upd_valid:
  - all valid ← 0.
  - all PHT ← 2'b01 (weakly not-taken).
  - GHR ← 0.
  - Reset asserted mid-run discards all learned state on that edge.
- Reset values of outputs, valid while reset is asserted from the cycle after the first reset edge:
  - pred_taken = 0.
  - pred_next_pc = if_pc + 4.
  - pred_ghr = 0.

## Timing
- Lookup latency 0 cycles: outputs follow `if_pc` combinationally in the same cycle.
- Update visible to lookups from the cycle after the edge that samples upd_valid. There is no write-to-read bypass.
  - A same-cycle lookup of the same index returns the pre-update prediction.
- One update per cycle, max. The core gates upd_valid with its own flush and stall logic.
- Misprediction detection and redirect are the core's responsibility. The block only predicts and trains.

## Configuration
- `BP_GSHARE_EN` defined: PHT index is pidx(pc, h) as above. GHR shifts on each update.
- `BP_GSHARE_EN` undefined: bimodal predictor.
  - PHT index is idx(pc).
  - GHR is held at 0, so pred_ghr = 0.
  - upd_ghr is ignored.
  - BTB behaviour is identical in both builds.

## Test plan
- Reset, then if_pc=0x100 → pred_taken=0, pred_next_pc=0x104, pred_ghr=0. Learn an entry, assert reset for one cycle, then lookup → miss.
- Bimodal build, ENTRIES=32: update pc=0x40, taken, target=0x80. Next cycle if_pc=0x40 → pred_taken=1, pred_next_pc=0x80 (counter 01→10).
- Bimodal saturation on pc=0x40:
  - 3 more taken updates → counter 11.
  - 1 not-taken → 10, still predicts 0x80.
  - 2 more not-taken → 00, pred_taken=0, pred_next_pc=0x44 despite BTB hit.
- Tag alias: after learning 0x40→0x80, if_pc=0xC0 (same idx 16, different tag) → miss, pred_next_pc=0xC4. Then a taken update of 0xC0→0x200 evicts 0x40, so lookup of 0x40 → miss.
- Gshare build:
  - Two taken updates of 0x40 with upd_ghr=0 → PHT[16]=11, pred_ghr=0b00011.
  - Lookup 0x40 uses PHT[19]=01 → pred_taken=0, pred_next_pc=0x44.
  - Updates taken, not-taken, not-taken from reset → pred_ghr=0b00100.
- Simultaneous: if_pc=0x40 while the first taken update of 0x40 is presented → that cycle pred_next_pc=0x44. Following cycle → 0x80 (bimodal build).
